// File: rtl/uc_pkg.sv
// Shared definitions for the multi-cycle RISC-V control unit: opcodes,
// ALU command encodings, flag positions, FSM states and instruction classes.
package uc_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_ADDI   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [3:0] ALU_R  = 4'b0000;
  localparam logic [3:0] ALU_I  = 4'b0001;
  localparam logic [3:0] ALU_S  = 4'b0010;
  localparam logic [3:0] ALU_SB = 4'b0011;
  localparam logic [3:0] ALU_U  = 4'b0100;
  localparam logic [3:0] ALU_UJ = 4'b0101;

  localparam int FLAG_ZERO = 0;
  localparam int FLAG_MSB  = 1;
  localparam int FLAG_OVF  = 2;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    HALT
  } state_t;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_ADDI,
    CLS_LOAD,
    CLS_STORE,
    CLS_BEQ,
    CLS_BNE,
    CLS_JAL,
    CLS_AUIPC
  } instr_class_t;

  // ALU command the datapath needs for a given instruction class
  function automatic logic [3:0] alu_cmd_of(instr_class_t c);
    case (c)
      CLS_R:             return ALU_R;
      CLS_ADDI, CLS_LOAD: return ALU_I;
      CLS_STORE:         return ALU_S;
      CLS_BEQ, CLS_BNE:  return ALU_SB;
      CLS_AUIPC:         return ALU_U;
      CLS_JAL:           return ALU_UJ;
      default:           return ALU_R;
    endcase
  endfunction

  // Classes whose second ALU operand is the immediate
  function automatic logic uses_imm(instr_class_t c);
    return (c == CLS_ADDI) || (c == CLS_LOAD) || (c == CLS_STORE) || (c == CLS_AUIPC);
  endfunction

endpackage

// File: rtl/uc_decoder.sv
// Combinational opcode/funct3 classifier; flags anything unsupported as illegal.
module uc_decoder
  import uc_pkg::*;
(
  input  logic [6:0]   opcode,
  input  logic [2:0]   funct3,
  output instr_class_t cls,
  output logic         illegal
);

  // Map the opcode (and funct3 for branches) to an instruction class
  always_comb begin
    cls     = CLS_R;
    illegal = 1'b0;
    case (opcode)
      OP_R:      cls = CLS_R;
      OP_ADDI:   cls = CLS_ADDI;
      OP_LOAD:   cls = CLS_LOAD;
      OP_STORE:  cls = CLS_STORE;
      OP_JAL:    cls = CLS_JAL;
      OP_AUIPC:  cls = CLS_AUIPC;
      OP_BRANCH: begin
        if (funct3 == F3_BEQ)      cls = CLS_BEQ;
        else if (funct3 == F3_BNE) cls = CLS_BNE;
        else                       illegal = 1'b1;
      end
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/uc_multiciclo.sv
// Multi-cycle control unit: sequences FETCH/DECODE/EXEC/MEM/WB, drives the
// datapath strobes, halts on unsupported instructions and counts retirements.
module uc_multiciclo
  import uc_pkg::*;
#(
  parameter int MEM_WAIT = 1,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [3:0]       alu_flags,
  output logic             rf_we,
  output logic             d_mem_we,
  output logic [3:0]       alu_cmd,
  output logic             alu_src,
  output logic             pc_src,
  output logic             rf_src,
  output logic             pc_we,
  output logic             halt,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [3:0] MEM_LAST = 4'(MEM_WAIT);

  state_t       state, state_next;
  instr_class_t cls_q, dec_cls;
  logic         dec_illegal;
  logic [3:0]   wait_cnt;
  logic         mem_last;
  logic         zero_flag;
  logic         branch_taken;
  logic         illegal_q;
  logic         unused_flags;

  uc_decoder u_decoder (
    .opcode  (opcode),
    .funct3  (funct3),
    .cls     (dec_cls),
    .illegal (dec_illegal)
  );

  assign mem_last     = (wait_cnt == MEM_LAST);
  assign zero_flag    = alu_flags[FLAG_ZERO];
  assign branch_taken = (cls_q == CLS_BEQ) ? zero_flag : ~zero_flag;
  assign unused_flags = ^{alu_flags[3], alu_flags[FLAG_OVF], alu_flags[FLAG_MSB]};
  assign illegal      = illegal_q;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Latch the instruction class in DECODE; remember a halt caused by an illegal op
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cls_q     <= CLS_R;
      illegal_q <= 1'b0;
    end else if (state == DECODE) begin
      cls_q <= dec_cls;
      if (dec_illegal) illegal_q <= 1'b1;
    end
  end

  // MEM wait counter: counts up while in MEM, cleared everywhere else
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                        wait_cnt <= 4'd0;
    else if (state == MEM && !mem_last) wait_cnt <= wait_cnt + 4'd1;
    else                               wait_cnt <= 4'd0;
  end

  // Retired-instruction counter, one increment per PC update
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     instr_count <= '0;
    else if (pc_we) instr_count <= instr_count + CNT_W'(1);
  end

  // Next-state logic and strobe decoding from state plus latched class
  always_comb begin
    state_next = state;
    rf_we      = 1'b0;
    d_mem_we   = 1'b0;
    alu_cmd    = ALU_R;
    alu_src    = 1'b0;
    pc_src     = 1'b0;
    rf_src     = 1'b0;
    pc_we      = 1'b0;
    halt       = 1'b0;
    case (state)
      IDLE:   if (start) state_next = FETCH;
      FETCH:  state_next = DECODE;
      DECODE: state_next = dec_illegal ? HALT : EXEC;
      EXEC: begin
        alu_cmd = alu_cmd_of(cls_q);
        alu_src = uses_imm(cls_q);
        case (cls_q)
          CLS_BEQ, CLS_BNE: begin
            pc_src     = branch_taken;
            pc_we      = 1'b1;
            state_next = FETCH;
          end
          CLS_JAL: begin
            pc_src     = 1'b1;
            pc_we      = 1'b1;
            state_next = FETCH;
          end
          CLS_LOAD, CLS_STORE: state_next = MEM;
          default:             state_next = WB;
        endcase
      end
      MEM: begin
        alu_cmd = alu_cmd_of(cls_q);
        alu_src = uses_imm(cls_q);
        if (mem_last) begin
          if (cls_q == CLS_STORE) begin
            d_mem_we   = 1'b1;
            pc_we      = 1'b1;
            state_next = FETCH;
          end else begin
            state_next = WB;
          end
        end
      end
      WB: begin
        alu_cmd    = alu_cmd_of(cls_q);
        alu_src    = uses_imm(cls_q);
        rf_we      = 1'b1;
        pc_we      = 1'b1;
        rf_src     = (cls_q == CLS_LOAD);
        state_next = FETCH;
      end
      HALT:    halt = 1'b1;
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uc_multiciclo.sv
// Directed, table-driven bench for uc_multiciclo with MEM_WAIT=1.
module tb_uc_multiciclo;

  localparam int K_WB    = 0;
  localparam int K_LOAD  = 1;
  localparam int K_STORE = 2;
  localparam int K_BR    = 3;
  localparam logic [11:0] ZERO_OUT = 12'h000;
  localparam logic [11:0] HALT_OUT = 12'h003;

  typedef struct {
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [3:0] flags;
    int         kind;
    int         lat;
    logic [3:0] cmd;
    logic       src;
    logic       pcs;
    logic       rfs;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [3:0]  alu_flags;
  logic        rf_we;
  logic        d_mem_we;
  logic [3:0]  alu_cmd;
  logic        alu_src;
  logic        pc_src;
  logic        rf_src;
  logic        pc_we;
  logic        halt;
  logic        illegal;
  logic [31:0] instr_count;

  int          checks;
  int          errors;
  logic [31:0] exp_cnt;
  vec_t        vecs[10];

  uc_multiciclo #(.MEM_WAIT(1), .CNT_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .opcode      (opcode),
    .funct3      (funct3),
    .alu_flags   (alu_flags),
    .rf_we       (rf_we),
    .d_mem_we    (d_mem_we),
    .alu_cmd     (alu_cmd),
    .alu_src     (alu_src),
    .pc_src      (pc_src),
    .rf_src      (rf_src),
    .pc_we       (pc_we),
    .halt        (halt),
    .illegal     (illegal),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {rf_we,d_mem_we,alu_cmd,alu_src,pc_src,rf_src,pc_we,halt,illegal}
  // for cycle k (1 = FETCH) of an instruction described by v
  function automatic logic [11:0] model(vec_t v, int k);
    logic [3:0] cmd  = 4'b0000;
    logic       src  = 1'b0;
    logic       rfwe = 1'b0;
    logic       dmw  = 1'b0;
    logic       pcs  = 1'b0;
    logic       rfs  = 1'b0;
    logic       pcw  = 1'b0;
    if (k >= 3) begin
      cmd = v.cmd;
      src = v.src;
    end
    if (k == v.lat) begin
      pcw = 1'b1;
      case (v.kind)
        K_BR:         pcs = v.pcs;
        K_WB, K_LOAD: begin rfwe = 1'b1; rfs = v.rfs; end
        K_STORE:      dmw = 1'b1;
        default:      pcw = 1'b1;
      endcase
    end
    return {rfwe, dmw, cmd, src, pcs, rfs, pcw, 1'b0, 1'b0};
  endfunction

  task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic [3:0] fl);
    opcode    = op;
    funct3    = f3;
    alu_flags = fl;
  endtask

  task automatic checkOutput(input string name, input int idx, input int k, input logic [11:0] exp_out);
    logic [11:0] act;
    act = {rf_we, d_mem_we, alu_cmd, alu_src, pc_src, rf_src, pc_we, halt, illegal};
    checks++;
    if (act !== exp_out) begin
      errors++;
      $display("[TB] FAIL %s vec %0d cycle %0d: outputs got %b expected %b", name, idx, k, act, exp_out);
    end
    checks++;
    if (instr_count !== exp_cnt) begin
      errors++;
      $display("[TB] FAIL %s_count vec %0d cycle %0d: instr_count got %0d expected %0d",
               name, idx, k, instr_count, exp_cnt);
    end
  endtask

  task automatic stepCheck(input string name, input logic [11:0] exp_out);
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput(name, -1, 0, exp_out);
  endtask

  // Run one full instruction cycle by cycle against the model
  task automatic runVector(input vec_t v, input int idx);
    applyStimulus(v.opcode, v.funct3, v.flags);
    for (int k = 1; k <= v.lat; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      checkOutput("vec", idx, k, model(v, k));
      if (k == v.lat) exp_cnt = exp_cnt + 32'd1;
    end
  endtask

  // Pulse the async reset mid-cycle and check outputs clear immediately
  task automatic doReset(input string name);
    #2 reset = 1'b0;
    exp_cnt = 32'd0;
    #1 checkOutput(name, -1, 0, ZERO_OUT);
    @(posedge clk);
    #2 reset = 1'b1;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    exp_cnt = 32'd0;
    reset   = 1'b0;
    start   = 1'b0;
    applyStimulus(7'b0, 3'b0, 4'b0);

    vecs[0] = '{7'b0110011, 3'b000, 4'b0000, K_WB,    4, 4'b0000, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{7'b0010011, 3'b000, 4'b0001, K_WB,    4, 4'b0001, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{7'b0000011, 3'b011, 4'b0000, K_LOAD,  6, 4'b0001, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{7'b0100011, 3'b011, 4'b0000, K_STORE, 5, 4'b0010, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{7'b1100011, 3'b000, 4'b0001, K_BR,    3, 4'b0011, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{7'b1100011, 3'b000, 4'b0110, K_BR,    3, 4'b0011, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{7'b1100011, 3'b001, 4'b0000, K_BR,    3, 4'b0011, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{7'b1100011, 3'b001, 4'b1001, K_BR,    3, 4'b0011, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{7'b1101111, 3'b000, 4'b0001, K_BR,    3, 4'b0101, 1'b0, 1'b1, 1'b0};
    vecs[9] = '{7'b0010111, 3'b000, 4'b0000, K_WB,    4, 4'b0100, 1'b1, 1'b0, 1'b0};

    #2 checkOutput("reset_state", -1, 0, ZERO_OUT);
    @(posedge clk);
    #2 reset = 1'b1;

    // Idle without start: nothing happens
    stepCheck("idle_no_start", ZERO_OUT);
    stepCheck("idle_no_start", ZERO_OUT);

    // Table-driven instruction stream started by a single start pulse
    start = 1'b1;
    for (int i = 0; i < 10; i++) runVector(vecs[i], i);

    // Unsupported opcode halts after DECODE and ignores start
    applyStimulus(7'b1110011, 3'b000, 4'b0000);
    stepCheck("ill_fetch", ZERO_OUT);
    stepCheck("ill_decode", ZERO_OUT);
    stepCheck("ill_halt", HALT_OUT);
    stepCheck("ill_halt", HALT_OUT);
    start = 1'b1;
    @(posedge clk); #1;
    checkOutput("halt_start_ignored", -1, 0, HALT_OUT);
    stepCheck("halt_start_ignored", HALT_OUT);
    doReset("reset_from_halt");

    // Branch with unsupported funct3 also halts
    applyStimulus(7'b1100011, 3'b100, 4'b0001);
    start = 1'b1;
    stepCheck("br100_fetch", ZERO_OUT);
    stepCheck("br100_decode", ZERO_OUT);
    stepCheck("br100_halt", HALT_OUT);
    stepCheck("br100_halt", HALT_OUT);
    doReset("reset_from_br100");

    // Reset asserted during the MEM phase of a LOAD
    start = 1'b1;
    runVector(vecs[0], 100);
    applyStimulus(vecs[2].opcode, vecs[2].funct3, vecs[2].flags);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      checkOutput("load_pre_reset", 102, k, model(vecs[2], k));
    end
    doReset("reset_mid_load");
    for (int k = 0; k < 4; k++) stepCheck("idle_after_reset", ZERO_OUT);

    // Restart works and counting begins again from zero
    start = 1'b1;
    runVector(vecs[0], 200);
    stepCheck("restart_count", ZERO_OUT);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
